// File: rtl/tm1638_pkg.sv
// Shared tm1638 constants: button count, default tick timing and the button-cell state type.
package tm1638_pkg;

    localparam int unsigned NUM_BUTTONS                 = 8;
    localparam int unsigned TICK_DIV_DEFAULT            = 1200;
    localparam int unsigned DEBOUNCE_TICKS_DEFAULT      = 100;
    localparam int unsigned REPEAT_DELAY_TICKS_DEFAULT  = 4000;
    localparam int unsigned REPEAT_PERIOD_TICKS_DEFAULT = 1000;

    typedef enum logic {
        BTN_STABLE   = 1'b0,
        BTN_CHANGING = 1'b1
    } btn_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tm1638_button_cell.sv
// One button: synchronizer, debounce FSM and auto-repeat timer.
module tm1638_button_cell
    import tm1638_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS      = DEBOUNCE_TICKS_DEFAULT,
    parameter int unsigned REPEAT_DELAY_TICKS  = REPEAT_DELAY_TICKS_DEFAULT,
    parameter int unsigned REPEAT_PERIOD_TICKS = REPEAT_PERIOD_TICKS_DEFAULT
) (
    input  logic CLK,
    input  logic RST_IN,
    input  logic tick,
    input  logic button_raw,
    output logic level,
    output logic press_c,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_TICKS);
    localparam int unsigned REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                                      REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int unsigned REP_W   = cnt_width(REP_MAX);

    logic             sync_meta;
    logic             sync_bit;
    btn_state_t       state;
    logic [DEB_W-1:0] deb_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             rep_armed;

    logic [DEB_W-1:0] deb_next_c;
    logic [REP_W-1:0] rep_next_c;
    logic [REP_W-1:0] rep_term_c;
    logic             flip_c;

    // Flip happens on the tick that completes the debounce interval of an unbroken difference.
    always_comb begin
        deb_next_c = deb_cnt + DEB_W'(1);
        rep_next_c = rep_cnt + REP_W'(1);
        rep_term_c = rep_armed ? REP_W'(REPEAT_PERIOD_TICKS) : REP_W'(REPEAT_DELAY_TICKS);
        flip_c     = (state == BTN_CHANGING) && (sync_bit != level) && tick &&
                     (deb_next_c == DEB_W'(DEBOUNCE_TICKS));
        press_c    = flip_c && !level;
    end

    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            sync_meta     <= 1'b0;
            sync_bit      <= 1'b0;
            state         <= BTN_STABLE;
            deb_cnt       <= '0;
            rep_cnt       <= '0;
            rep_armed     <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync_meta     <= button_raw;
            sync_bit      <= sync_meta;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                BTN_STABLE: begin
                    deb_cnt <= '0;
                    if (sync_bit != level) state <= BTN_CHANGING;
                end
                BTN_CHANGING: begin
                    if (sync_bit == level) begin
                        state   <= BTN_STABLE;
                        deb_cnt <= '0;
                    end else if (flip_c) begin
                        state         <= BTN_STABLE;
                        deb_cnt       <= '0;
                        level         <= ~level;
                        press_pulse   <= ~level;
                        release_pulse <= level;
                        repeat_pulse  <= ~level;
                    end else if (tick) begin
                        deb_cnt <= deb_next_c;
                    end
                end
                default: state <= BTN_STABLE;
            endcase

            // Repeat timer restarts on any flip; a repeat landing on the release tick is dropped.
            if (flip_c) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
            end else if (level && tick) begin
                if (rep_next_c == rep_term_c) begin
                    repeat_pulse <= 1'b1;
                    rep_cnt      <= '0;
                    rep_armed    <= 1'b1;
                end else begin
                    rep_cnt <= rep_next_c;
                end
            end
        end
    end

endmodule

// File: rtl/tm1638_button_filter.sv
// Debounce and auto-repeat for the eight tm1638 key-scan bits, sharing one tick prescaler.
module tm1638_button_filter
    import tm1638_pkg::*;
#(
    parameter int unsigned TICK_DIV            = TICK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_TICKS      = DEBOUNCE_TICKS_DEFAULT,
    parameter int unsigned REPEAT_DELAY_TICKS  = REPEAT_DELAY_TICKS_DEFAULT,
    parameter int unsigned REPEAT_PERIOD_TICKS = REPEAT_PERIOD_TICKS_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST_IN,
    input  logic [NUM_BUTTONS-1:0] BUTTONS_IN,
    output logic [NUM_BUTTONS-1:0] BUTTONS_OUT,
    output logic [NUM_BUTTONS-1:0] PRESS,
    output logic [NUM_BUTTONS-1:0] RELEASE,
    output logic [NUM_BUTTONS-1:0] REPEAT,
    output logic                   ANY_PRESS
);

    localparam int unsigned PRE_W = cnt_width(TICK_DIV - 1);

    logic [PRE_W-1:0]       pre_cnt;
    logic                   tick;
    logic [NUM_BUTTONS-1:0] press_vec_c;

    // Tick is high for the one cycle in which the prescaler sits at 0 after wrapping.
    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_W'(TICK_DIV - 1));
            pre_cnt <= (pre_cnt == PRE_W'(TICK_DIV - 1)) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_IN) ANY_PRESS <= 1'b0;
        else        ANY_PRESS <= |press_vec_c;
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
        tm1638_button_cell #(
            .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
            .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
            .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
        ) u_cell (
            .CLK           (CLK),
            .RST_IN        (RST_IN),
            .tick          (tick),
            .button_raw    (BUTTONS_IN[i]),
            .level         (BUTTONS_OUT[i]),
            .press_c       (press_vec_c[i]),
            .press_pulse   (PRESS[i]),
            .release_pulse (RELEASE[i]),
            .repeat_pulse  (REPEAT[i])
        );
    end

endmodule
